// File: rtl/matmul_pkg.sv
// Shared constants, register map and types for the matmul accelerator APB front-end.
package matmul_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BUS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int IDX_W      = $clog2(MAX_DIM);
    localparam int LINE_W     = 2 * IDX_W;

    // Register index is paddr[4:2]; indices 4..7 are the SP0..SP3 windows.
    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_A       = 3'd1;
    localparam logic [2:0] REG_B       = 3'd2;
    localparam logic [2:0] REG_FLAGS   = 3'd3;

    localparam int                   CTRL_START_BIT = 0;
    localparam logic [BUS_WIDTH-1:0] CTRL_WMASK     = 32'h0000_3F3E;

    typedef struct packed {
        logic [17:0] rsvd_hi;
        logic [1:0]  m_m1;
        logic [1:0]  k_m1;
        logic [1:0]  n_m1;
        logic [1:0]  rsvd_lo;
        logic [1:0]  rd_tgt;
        logic [1:0]  wr_tgt;
        logic        mode;
        logic        start;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SPW  = 2'd2,
        ST_ERR  = 2'd3
    } apb_state_t;

    function automatic logic [BUS_WIDTH-1:0] strb_merge(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [MAX_DIM-1:0]   strb
    );
        logic [BUS_WIDTH-1:0] res;
        res = old_v;
        for (int k = 0; k < MAX_DIM; k++) begin
            if (strb[k]) begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = new_v[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = old_v[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_apb_regbank.sv
// Byte-lane masked MAX_DIM x BUS_WIDTH register bank with a flat view and one read port.
module matmul_apb_regbank
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_line,
    input  logic [MAX_DIM-1:0]           wr_strb,
    input  logic [BUS_WIDTH-1:0]         wr_data,
    input  logic [IDX_W-1:0]             rd_line,
    output logic [BUS_WIDTH-1:0]         rd_data,
    output logic [BUS_WIDTH*MAX_DIM-1:0] bank
);

    logic [BUS_WIDTH-1:0] mem_r [MAX_DIM];

    // Line storage with per-lane write enables
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                mem_r[i] <= {BUS_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_line] <= strb_merge(mem_r[wr_line], wr_data, wr_strb);
        end else begin
            mem_r[wr_line] <= mem_r[wr_line];
        end
    end

    // Flattened bank view and read port
    always_comb begin
        bank = {(BUS_WIDTH*MAX_DIM){1'b0}};
        for (int i = 0; i < MAX_DIM; i++) begin
            bank[i*BUS_WIDTH +: BUS_WIDTH] = mem_r[i];
        end
        rd_data = mem_r[rd_line];
    end

endmodule

// File: rtl/matmul_apb_slave.sv
// APB completer for the matmul accelerator: register map decode, CONTROL/A/B banks,
// and scratchpad read forwarding over a request/valid port.
module matmul_apb_slave
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [MAX_DIM-1:0]           pstrb_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    input  logic [BUS_WIDTH-1:0]         pwdata_i,
    output logic [BUS_WIDTH-1:0]         prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    input  logic                         busy_i,
    input  logic [BUS_WIDTH-1:0]         flags_i,
    output logic [BUS_WIDTH-1:0]         control_o,
    output logic                         start_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opa_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opb_o,
    output logic                         sp_rd_req_o,
    output logic [1:0]                   sp_rd_sel_o,
    output logic [LINE_W-1:0]            sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]         sp_rd_data_i,
    input  logic                         sp_rd_valid_i
);

    apb_state_t           state_r, next_state_s;
    logic                 setup_s, dec_err_s, sp_read_s;
    logic [2:0]           reg_idx_s, reg_idx_r;
    logic [LINE_W-1:0]    line_s, line_r;
    logic                 write_r;
    logic [BUS_WIDTH-1:0] wdata_r;
    logic [MAX_DIM-1:0]   strb_r;
    logic                 commit_s, ctrl_we_s, a_we_s, b_we_s;
    logic [BUS_WIDTH-1:0] rd_mux_s, a_rd_s, b_rd_s, prdata_r;
    ctrl_t                control_r;
    logic                 start_r;
    logic                 unused_paddr_s;

    assign unused_paddr_s = ^paddr_i[ADDR_WIDTH-1:5+LINE_W];

    // Setup-phase address decode and error classification
    always_comb begin
        setup_s   = psel_i & ~penable_i;
        reg_idx_s = paddr_i[4:2];
        line_s    = paddr_i[5 +: LINE_W];
        sp_read_s = reg_idx_s[2] & ~pwrite_i;
        if (paddr_i[1:0] != 2'b00) begin
            dec_err_s = 1'b1;
        end else if (pwrite_i && (reg_idx_s >= REG_FLAGS)) begin
            dec_err_s = 1'b1;
        end else if (pwrite_i && busy_i) begin
            dec_err_s = 1'b1;
        end else if (((reg_idx_s == REG_A) || (reg_idx_s == REG_B)) && (line_s >= LINE_W'(MAX_DIM))) begin
            dec_err_s = 1'b1;
        end else if (((reg_idx_s == REG_CONTROL) || (reg_idx_s == REG_FLAGS)) && (line_s != {LINE_W{1'b0}})) begin
            dec_err_s = 1'b1;
        end else begin
            dec_err_s = 1'b0;
        end
    end

    // Register read mux, evaluated on the setup address so reads need no wait state
    always_comb begin
        case (reg_idx_s)
            REG_CONTROL: rd_mux_s = control_r;
            REG_A:       rd_mux_s = a_rd_s;
            REG_B:       rd_mux_s = b_rd_s;
            REG_FLAGS:   rd_mux_s = flags_i;
            default:     rd_mux_s = {BUS_WIDTH{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; dropping psel during a wait abandons the transfer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!setup_s)       next_state_s = ST_IDLE;
                else if (dec_err_s) next_state_s = ST_ERR;
                else if (sp_read_s) next_state_s = ST_SPW;
                else                next_state_s = ST_ACC;
            end
            ST_ACC: next_state_s = ST_IDLE;
            ST_SPW: begin
                if (!psel_i)            next_state_s = ST_IDLE;
                else if (sp_rd_valid_i) next_state_s = ST_ACC;
                else                    next_state_s = ST_SPW;
            end
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the SP request goes out with the setup phase to save a wait state
    always_comb begin
        pready_o     = (state_r == ST_ACC) || (state_r == ST_ERR);
        pslverr_o    = (state_r == ST_ERR);
        sp_rd_req_o  = 1'b0;
        sp_rd_sel_o  = 2'b00;
        sp_rd_addr_o = {LINE_W{1'b0}};
        if ((state_r == ST_IDLE) && setup_s && sp_read_s && !dec_err_s && !rst_i) begin
            sp_rd_req_o  = 1'b1;
            sp_rd_sel_o  = reg_idx_s[1:0];
            sp_rd_addr_o = line_s;
        end else if (state_r == ST_SPW) begin
            sp_rd_sel_o  = reg_idx_r[1:0];
            sp_rd_addr_o = line_r;
        end else begin
            sp_rd_req_o  = 1'b0;
        end
    end

    // Transfer attributes captured in the setup phase
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_idx_r <= 3'd0;
            line_r    <= {LINE_W{1'b0}};
            write_r   <= 1'b0;
            wdata_r   <= {BUS_WIDTH{1'b0}};
            strb_r    <= {MAX_DIM{1'b0}};
        end else if ((state_r == ST_IDLE) && setup_s) begin
            reg_idx_r <= reg_idx_s;
            line_r    <= line_s;
            write_r   <= pwrite_i;
            wdata_r   <= pwdata_i;
            strb_r    <= pstrb_i;
        end else begin
            reg_idx_r <= reg_idx_r;
            line_r    <= line_r;
            write_r   <= write_r;
            wdata_r   <= wdata_r;
            strb_r    <= strb_r;
        end
    end

    assign commit_s  = (state_r == ST_ACC) && psel_i && write_r;
    assign ctrl_we_s = commit_s && (reg_idx_r == REG_CONTROL);
    assign a_we_s    = commit_s && (reg_idx_r == REG_A);
    assign b_we_s    = commit_s && (reg_idx_r == REG_B);

    // Read data: register value at setup, SP data on valid, zero for errors and writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prdata_r <= {BUS_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && setup_s) begin
            prdata_r <= (dec_err_s || pwrite_i || sp_read_s) ? {BUS_WIDTH{1'b0}} : rd_mux_s;
        end else if ((state_r == ST_SPW) && psel_i && sp_rd_valid_i) begin
            prdata_r <= sp_rd_data_i;
        end else begin
            prdata_r <= prdata_r;
        end
    end

    // CONTROL register; start bit is turned into a pulse and never stored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            control_r <= ctrl_t'({BUS_WIDTH{1'b0}});
            start_r   <= 1'b0;
        end else if (ctrl_we_s) begin
            control_r <= ctrl_t'(strb_merge(control_r, wdata_r, strb_r) & CTRL_WMASK);
            start_r   <= strb_r[0] & wdata_r[CTRL_START_BIT] & ~busy_i;
        end else begin
            control_r <= control_r;
            start_r   <= 1'b0;
        end
    end

    matmul_apb_regbank u_bank_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (a_we_s),
        .wr_line (line_r[IDX_W-1:0]),
        .wr_strb (strb_r),
        .wr_data (wdata_r),
        .rd_line (line_s[IDX_W-1:0]),
        .rd_data (a_rd_s),
        .bank    (opa_o)
    );

    matmul_apb_regbank u_bank_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (b_we_s),
        .wr_line (line_r[IDX_W-1:0]),
        .wr_strb (strb_r),
        .wr_data (wdata_r),
        .rd_line (line_s[IDX_W-1:0]),
        .rd_data (b_rd_s),
        .bank    (opb_o)
    );

    assign prdata_o  = prdata_r;
    assign control_o = control_r;
    assign start_o   = start_r;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed scenarios plus randomized traffic
// compared against a register-map model kept in the bench.
module tb_matmul_apb_slave;
    import matmul_pkg::*;

    logic         clk = 1'b0;
    logic         rst, psel, penable, pwrite, busy;
    logic [3:0]   pstrb;
    logic [31:0]  paddr, pwdata, prdata, flags, control;
    logic         pready, pslverr, start;
    logic [127:0] opa, opb;
    logic         sp_rd_req, sp_rd_valid;
    logic [1:0]   sp_rd_sel;
    logic [3:0]   sp_rd_addr;
    logic [31:0]  sp_rd_data;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] a_m [4];
    logic [31:0] b_m [4];
    logic [31:0] ctrl_m;
    logic [31:0] sp_mem [4][16];
    int          sp_lat = 1;
    logic [1:0]  sel_seen;
    logic [3:0]  addr_seen;
    int          req_cnt;

    always #5 clk = ~clk;

    matmul_apb_slave dut (
        .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .busy_i(busy), .flags_i(flags),
        .control_o(control), .start_o(start), .opa_o(opa), .opb_o(opb),
        .sp_rd_req_o(sp_rd_req), .sp_rd_sel_o(sp_rd_sel), .sp_rd_addr_o(sp_rd_addr),
        .sp_rd_data_i(sp_rd_data), .sp_rd_valid_i(sp_rd_valid)
    );

    // Scratchpad array: answers each request sp_lat cycles later with one valid cycle
    initial begin : sp_responder
        int          lat_l;
        logic [31:0] d;
        sp_rd_valid = 1'b0;
        sp_rd_data  = 32'h0;
        req_cnt     = 0;
        forever begin
            @(negedge clk);
            if (sp_rd_req === 1'b1) begin
                sel_seen  = sp_rd_sel;
                addr_seen = sp_rd_addr;
                req_cnt++;
                lat_l = sp_lat;
                d     = sp_mem[sp_rd_sel][sp_rd_addr];
                repeat (lat_l) @(posedge clk);
                #1;
                sp_rd_valid = 1'b1;
                sp_rd_data  = d;
                @(posedge clk);
                #1;
                sp_rd_valid = 1'b0;
                sp_rd_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic bit exp_err(input logic [31:0] addr, input bit wr, input bit bz);
        int r, line;
        r    = (addr % 32) / 4;
        line = (addr / 32) % 16;
        if (addr % 4 != 0) return 1'b1;
        if (wr && r >= 3) return 1'b1;
        if (wr && bz) return 1'b1;
        if ((r == 1 || r == 2) && line >= 4) return 1'b1;
        if ((r == 0 || r == 3) && line != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        int r, line;
        r    = (addr % 32) / 4;
        line = (addr / 32) % 16;
        case (r)
            0: return ctrl_m;
            1: return a_m[line];
            2: return b_m[line];
            3: return flags;
            default: return sp_mem[r-4][line];
        endcase
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        int r, line;
        r    = (addr % 32) / 4;
        line = (addr / 32) % 16;
        if (r == 0) ctrl_m = merge(ctrl_m, d, s) & 32'h0000_3F3E;
        else if (r == 1) a_m[line] = merge(a_m[line], d, s);
        else if (r == 2) b_m[line] = merge(b_m[line], d, s);
    endtask

    task automatic model_clear();
        ctrl_m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a_m[i] = 32'h0;
            b_m[i] = 32'h0;
        end
    endtask

    // One APB transfer starting in the current cycle (called #1 after a rising edge)
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rdata, output logic err,
                            output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (pready !== 1'b1 && waits < 30) begin
            @(posedge clk); #1;
            waits++;
        end
        if (pready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL xfer_timeout addr=%h: pready never rose", addr);
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({pready, pslverr, start, sp_rd_req} !== 4'b0000 || prdata !== 32'h0 || control !== 32'h0
            || opa !== 128'h0 || opb !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b err=%b st=%b req=%b prdata=%h ctrl=%h opa=%h opb=%h, want all 0",
                     pready, pslverr, start, sp_rd_req, prdata, control, opa, opb);
        end
    endtask

    task automatic test_write_a();
        logic [31:0] rd; logic e; int w;
        apb_xfer(32'h44, 1'b1, 32'h0403_0201, 4'hF, rd, e, w);
        model_write(32'h44, 32'h0403_0201, 4'hF);
        n_cmp++;
        if (e !== 1'b0 || w != 0) begin
            n_fail++; $display("FAIL write_a_resp: err=%b waits=%0d, want 0/0", e, w);
        end
        n_cmp++;
        if (opa[95:64] !== 32'h0403_0201) begin
            n_fail++; $display("FAIL write_a_line2: got %h want 04030201", opa[95:64]);
        end
        n_cmp++;
        if (pready !== 1'b0) begin
            n_fail++; $display("FAIL write_a_pready_len: pready still %b after completion", pready);
        end
    endtask

    task automatic test_strobe_b();
        logic [31:0] rd; logic e; int w;
        apb_xfer(32'h28, 1'b1, 32'h1122_3344, 4'hF, rd, e, w);
        apb_xfer(32'h28, 1'b1, 32'hAABB_CCDD, 4'b0011, rd, e, w);
        model_write(32'h28, 32'h1122_3344, 4'hF);
        model_write(32'h28, 32'hAABB_CCDD, 4'b0011);
        apb_xfer(32'h28, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== 32'h1122_CCDD || e !== 1'b0 || w != 0) begin
            n_fail++; $display("FAIL strobe_b_readback: got %h err=%b waits=%0d want 1122ccdd/0/0", rd, e, w);
        end
    endtask

    task automatic test_control();
        logic [31:0] rd; logic e; int w;
        apb_xfer(32'h00, 1'b1, 32'h0000_2A27, 4'hF, rd, e, w);
        model_write(32'h00, 32'h0000_2A27, 4'hF);
        n_cmp++;
        if (start !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL ctrl_start: start=%b err=%b want 1/0", start, e);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (start !== 1'b0) begin
            n_fail++; $display("FAIL ctrl_start_width: start=%b one cycle later, want 0", start);
        end
        apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== 32'h0000_2A26 || control !== 32'h0000_2A26) begin
            n_fail++; $display("FAIL ctrl_readback: rd=%h control=%h want 00002a26", rd, control);
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd; logic e; int w; logic [127:0] opa_before;
        busy = 1'b1;
        flags = $urandom;
        opa_before = opa;
        apb_xfer(32'h10, 1'b1, 32'h5555_5555, 4'hF, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || w != 0) begin
            n_fail++; $display("FAIL busy_sp_write: err=%b waits=%0d want 1/0", e, w);
        end
        apb_xfer(32'h04, 1'b1, 32'h7777_7777, 4'hF, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || opa !== opa_before) begin
            n_fail++; $display("FAIL busy_a_write: err=%b opa=%h want 1/%h", e, opa, opa_before);
        end
        apb_xfer(32'h00, 1'b1, 32'h0000_0001, 4'hF, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || start !== 1'b0) begin
            n_fail++; $display("FAIL busy_ctrl_write: err=%b start=%b want 1/0", e, start);
        end
        apb_xfer(32'h0C, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== flags || e !== 1'b0) begin
            n_fail++; $display("FAIL busy_flags_read: got %h err=%b want %h/0", rd, e, flags);
        end
        apb_xfer(32'h44, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== a_m[2] || e !== 1'b0) begin
            n_fail++; $display("FAIL busy_a_read: got %h err=%b want %h/0", rd, e, a_m[2]);
        end
        busy = 1'b0;
    endtask

    task automatic test_sp_read();
        logic [31:0] rd; logic e; int w;
        for (int t = 0; t < 2; t++) begin
            sp_lat = (t == 0) ? 1 : 3;
            apb_xfer(32'hB8, 1'b0, 32'h0, 4'h0, rd, e, w);
            n_cmp++;
            if (sel_seen !== 2'd2 || addr_seen !== 4'd5) begin
                n_fail++; $display("FAIL sp_req_addr: sel=%0d addr=%0d want 2/5", sel_seen, addr_seen);
            end
            n_cmp++;
            if (w != sp_lat || rd !== sp_mem[2][5] || e !== 1'b0) begin
                n_fail++; $display("FAIL sp_read_lat%0d: waits=%0d data=%h err=%b want %0d/%h/0",
                                   sp_lat, w, rd, e, sp_lat, sp_mem[2][5]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int w; logic [127:0] opa_before;
        opa_before = opa;
        apb_xfer(32'h06, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || rd !== 32'h0 || w != 0) begin
            n_fail++; $display("FAIL err_misaligned: err=%b rd=%h waits=%0d want 1/0/0", e, rd, w);
        end
        apb_xfer(32'h84, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || opa !== opa_before) begin
            n_fail++; $display("FAIL err_a_line4: err=%b opa=%h want 1/%h", e, opa, opa_before);
        end
        apb_xfer(32'h20, 1'b1, 32'h0000_0F00, 4'hF, rd, e, w);
        n_cmp++;
        if (e !== 1'b1 || control !== ctrl_m) begin
            n_fail++; $display("FAIL err_ctrl_line1: err=%b control=%h want 1/%h", e, control, ctrl_m);
        end
        n_cmp++;
        if (pslverr !== 1'b0) begin
            n_fail++; $display("FAIL err_pslverr_width: pslverr=%b after completion, want 0", pslverr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int w; int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            apb_xfer(32'((i << 5) | 8), 1'b1, d, 4'hF, rd, e, w);
            model_write(32'((i << 5) | 8), d, 4'hF);
            if (e !== 1'b0 || w != 0) bad++;
        end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(32'((i << 5) | 8), 1'b0, 32'h0, 4'h0, rd, e, w);
            if (rd !== b_m[i] || e !== 1'b0 || w != 0) bad++;
        end
        n_cmp++;
        if (bad != 0 || opb !== {b_m[3], b_m[2], b_m[1], b_m[0]}) begin
            n_fail++; $display("FAIL back_to_back: %0d bad transfers, opb=%h", bad, opb);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, d; logic e, exp_e, wr, exp_st; int w, r, line, mis; logic [3:0] s;
        int bad_err, bad_data, bad_wait, bad_state;
        bad_err = 0; bad_data = 0; bad_wait = 0; bad_state = 0;
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 7);
            if (r >= 4) line = $urandom_range(0, 15);
            else if ($urandom_range(0, 7) == 0) line = $urandom_range(1, 6);
            else if (r == 1 || r == 2) line = $urandom_range(0, 3);
            else line = 0;
            mis  = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
            addr = 32'(line * 32 + r * 4 + mis);
            wr   = (r < 4) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 4) == 0);
            flags = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            sp_lat = $urandom_range(1, 3);
            exp_e  = exp_err(addr, wr, busy);
            exp_st = !exp_e && wr && r == 0 && s[0] && d[0];
            apb_xfer(addr, wr, d, s, rd, e, w);
            if (e !== exp_e) bad_err++;
            if (w != ((!exp_e && !wr && r >= 4) ? sp_lat : 0)) bad_wait++;
            if (!wr && rd !== (exp_e ? 32'h0 : exp_read(addr))) bad_data++;
            if (!exp_e && wr) model_write(addr, d, s);
            if (start !== exp_st || control !== ctrl_m || opa !== {a_m[3], a_m[2], a_m[1], a_m[0]}
                || opb !== {b_m[3], b_m[2], b_m[1], b_m[0]}) bad_state++;
            busy = 1'b0;
        end
        n_cmp++;
        if (bad_err != 0) begin n_fail++; $display("FAIL rand_pslverr: %0d wrong, want 0", bad_err); end
        n_cmp++;
        if (bad_wait != 0) begin n_fail++; $display("FAIL rand_waits: %0d wrong, want 0", bad_wait); end
        n_cmp++;
        if (bad_data != 0) begin n_fail++; $display("FAIL rand_rdata: %0d wrong, want 0", bad_data); end
        n_cmp++;
        if (bad_state != 0) begin n_fail++; $display("FAIL rand_state: %0d wrong, want 0", bad_state); end
    endtask

    task automatic test_reset_spw();
        logic [31:0] rd; logic e; int w; int hi;
        apb_xfer(32'h04, 1'b1, 32'hCAFE_F00D, 4'hF, rd, e, w);
        sp_lat = 6;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h18;
        @(posedge clk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_clear();
        n_cmp++;
        if ({pready, pslverr, start, sp_rd_req} !== 4'b0000 || prdata !== 32'h0 || sp_rd_sel !== 2'd0
            || opa !== 128'h0 || control !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_spw: rdy=%b err=%b req=%b sel=%0d prdata=%h opa=%h, want 0",
                               pready, pslverr, sp_rd_req, sp_rd_sel, prdata, opa);
        end
        hi = 0;
        repeat (10) begin @(posedge clk); #1; if (pready !== 1'b0) hi++; end
        n_cmp++;
        if (hi != 0) begin n_fail++; $display("FAIL rst_late_valid: pready high %0d cycles, want 0", hi); end
        apb_xfer(32'h0C, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== flags || e !== 1'b0 || w != 0) begin
            n_fail++; $display("FAIL rst_then_read: rd=%h err=%b waits=%0d want %h/0/0", rd, e, w, flags);
        end
    endtask

    task automatic test_abort_spw();
        logic [31:0] rd; logic e; int w; int hi;
        sp_lat = 4;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h34;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        hi = 0;
        repeat (8) begin @(posedge clk); #1; if (pready !== 1'b0) hi++; end
        n_cmp++;
        if (hi != 0) begin n_fail++; $display("FAIL abort_late_valid: pready high %0d cycles, want 0", hi); end
        sp_lat = 1;
        apb_xfer(32'h34, 1'b0, 32'h0, 4'h0, rd, e, w);
        n_cmp++;
        if (rd !== sp_mem[1][1] || e !== 1'b0 || w != 1) begin
            n_fail++; $display("FAIL abort_then_sp: rd=%h err=%b waits=%0d want %h/0/1", rd, e, w, sp_mem[1][1]);
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
        paddr = 32'h0; pwdata = 32'h0; busy = 1'b0; flags = 32'h1357_9BDF;
        model_clear();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) sp_mem[i][j] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_write_a();
        test_strobe_b();
        test_control();
        test_busy();
        test_sp_read();
        test_errors();
        test_back_to_back();
        test_random();
        test_abort_spw();
        test_reset_spw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
